// File: rtl/s298_resp_misr.sv
// Response compactor for the s298 controller: folds a programmed number of output
// vectors into a 16-bit MISR signature and counts vector changes. Optional S298_RESP_XMASK_EN adds an XMASK input.
module s298_resp_misr #(
    parameter int unsigned    SIG_W = 16,
    parameter int unsigned    CYC_W = 10,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = 16'hFFFF
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic [CYC_W-1:0] NCYC,
    input  logic             G66,
    input  logic             G67,
    input  logic             G117,
    input  logic             G118,
    input  logic             G132,
    input  logic             G133,
`ifdef S298_RESP_XMASK_EN
    input  logic [5:0]       XMASK,
`endif
    input  logic             SIG_ACK,
    output logic             BUSY,
    output logic [SIG_W-1:0] SIG,
    output logic             SIG_VALID,
    output logic [15:0]      TOGGLES
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [CYC_W-1:0]   count;
    logic [5:0]         prev;
    logic [5:0]         vec;
    logic [SIG_W-1:0]   sig_next;

`ifdef S298_RESP_XMASK_EN
    assign vec = {G133, G132, G118, G117, G67, G66} & ~XMASK;
`else
    assign vec = {G133, G132, G118, G117, G67, G66};
`endif

    assign sig_next = {SIG[SIG_W-2:0], 1'b0}
                    ^ (SIG[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-6){1'b0}}, vec};

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            SIG       <= '0;
            TOGGLES   <= '0;
            BUSY      <= 1'b0;
            SIG_VALID <= 1'b0;
            count     <= '0;
            prev      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START && (NCYC != '0)) begin
                        SIG     <= SEED;
                        TOGGLES <= '0;
                        count   <= NCYC;
                        prev    <= vec;
                        BUSY    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    SIG <= sig_next;
                    if ((vec != prev) && (TOGGLES != 16'hFFFF))
                        TOGGLES <= TOGGLES + 16'd1;
                    prev  <= vec;
                    count <= count - 1'b1;
                    // Last capture: result is presented on this very edge
                    if (count == {{(CYC_W-1){1'b0}}, 1'b1}) begin
                        BUSY      <= 1'b0;
                        SIG_VALID <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (SIG_ACK) begin
                        SIG_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    BUSY      <= 1'b0;
                    SIG_VALID <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s298_resp_misr.sv
// Self-checking bench for s298_resp_misr: directed table, protocol sequences and
// randomized runs against an arithmetic signature model.
module tb_s298_resp_misr;

    localparam int SIG_W = 16;
    localparam int CYC_W = 10;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic             CK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [CYC_W-1:0] NCYC = '0;
    logic             G66 = 0, G67 = 0, G117 = 0, G118 = 0, G132 = 0, G133 = 0;
    logic             SIG_ACK = 1'b0;
    logic             BUSY;
    logic [SIG_W-1:0] SIG;
    logic             SIG_VALID;
    logic [15:0]      TOGGLES;

    int checks = 0;
    int failures = 0;

    s298_resp_misr dut (
        .CK(CK), .RST(RST), .START(START), .NCYC(NCYC),
        .G66(G66), .G67(G67), .G117(G117), .G118(G118), .G132(G132), .G133(G133),
        .SIG_ACK(SIG_ACK), .BUSY(BUSY), .SIG(SIG), .SIG_VALID(SIG_VALID), .TOGGLES(TOGGLES)
    );

    always #5 CK = ~CK;

    typedef struct {
        int          ncyc;
        logic [5:0]  v0;
        logic [5:0]  caps [8];
        bit          chk_sig;
        logic [15:0] exp_sig;
        logic [15:0] exp_tog;
    } vec_t;

    vec_t        tbl [5];
    logic [5:0]  vq [$];
    logic [15:0] m_sig, m_tog;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input logic [5:0] v);
        {G133, G132, G118, G117, G67, G66} = v;
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Signature and change count straight from the compaction rules, using integer math.
    task automatic model(input int n);
        int unsigned s, t;
        logic [5:0] p;
        s = SEED;
        t = 0;
        p = vq[0];
        for (int i = 1; i <= n; i++) begin
            s = ((s * 2) % 65536) ^ ((s >= 32768) ? POLY : 0) ^ vq[i];
            if (vq[i] != p && t < 65535) t = t + 1;
            p = vq[i];
        end
        m_sig = s[15:0];
        m_tog = t[15:0];
    endtask

    // Drives vq[0] on the START edge and vq[1..n] on the capture edges.
    // A nonzero pulse_at raises START (NCYC=1) during that capture edge.
    task automatic do_run(input string tag, input int n, input int pulse_at);
        START = 1'b1;
        NCYC = n[CYC_W-1:0];
        set_vec(vq[0]);
        tick();
        START = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (BUSY !== 1'b1 || SIG_VALID !== 1'b0)
                check({tag, "_run_flags"}, {30'b0, BUSY, SIG_VALID}, 32'h2);
            START = (i == pulse_at);
            NCYC = (i == pulse_at) ? 10'd1 : NCYC;
            set_vec(vq[i]);
            tick();
            START = 1'b0;
        end
        check({tag, "_valid"}, {31'b0, SIG_VALID}, 32'h1);
        check({tag, "_busy_done"}, {31'b0, BUSY}, 32'h0);
    endtask

    task automatic do_ack(input string tag);
        SIG_ACK = 1'b1;
        tick();
        SIG_ACK = 1'b0;
        check({tag, "_ack_valid"}, {31'b0, SIG_VALID}, 32'h0);
    endtask

    logic [15:0] held_sig, held_tog;
    int          busy_cnt;

    initial begin
        tbl[0] = '{1, 6'h00, '{6'h00, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 16'hEFDF, 16'd0};
        tbl[1] = '{2, 6'h00, '{6'h00, 6'h00, 0, 0, 0, 0, 0, 0}, 1'b1, 16'hCF9F, 16'd0};
        tbl[2] = '{1, 6'h3F, '{6'h3F, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 16'hEFE0, 16'd0};
        tbl[3] = '{4, 6'h00, '{6'h3F, 6'h00, 6'h3F, 6'h00, 0, 0, 0, 0}, 1'b0, 16'h0, 16'd4};
        tbl[4] = '{3, 6'h01, '{6'h01, 6'h01, 6'h02, 0, 0, 0, 0, 0}, 1'b0, 16'h0, 16'd1};

        // Reset state
        tick();
        tick();
        RST = 1'b0;
        check("rst_sig", {16'b0, SIG}, 32'h0);
        check("rst_tog", {16'b0, TOGGLES}, 32'h0);
        check("rst_busy", {31'b0, BUSY}, 32'h0);
        check("rst_valid", {31'b0, SIG_VALID}, 32'h0);

        // START with NCYC=0 is ignored
        START = 1'b1;
        NCYC = '0;
        tick();
        START = 1'b0;
        check("ncyc0_busy", {31'b0, BUSY}, 32'h0);
        tick();
        check("ncyc0_busy2", {31'b0, BUSY}, 32'h0);
        check("ncyc0_sig", {16'b0, SIG}, 32'h0);

        // Directed table
        foreach (tbl[k]) begin
            vq.delete();
            vq.push_back(tbl[k].v0);
            for (int i = 0; i < tbl[k].ncyc; i++) vq.push_back(tbl[k].caps[i]);
            do_run($sformatf("tbl%0d", k), tbl[k].ncyc, 0);
            model(tbl[k].ncyc);
            if (tbl[k].chk_sig) check($sformatf("tbl%0d_sig", k), {16'b0, SIG}, {16'b0, tbl[k].exp_sig});
            check($sformatf("tbl%0d_tog", k), {16'b0, TOGGLES}, {16'b0, tbl[k].exp_tog});
            check($sformatf("tbl%0d_model_sig", k), {16'b0, SIG}, {16'b0, m_sig});
            if (k == 3) begin
                // Hold without ack, with START pulses that must not matter
                held_sig = SIG;
                held_tog = TOGGLES;
                for (int c = 0; c < 5; c++) begin
                    START = (c == 2);
                    NCYC = 10'd3;
                    tick();
                    START = 1'b0;
                    check($sformatf("hold_valid_%0d", c), {31'b0, SIG_VALID}, 32'h1);
                end
                check("hold_sig", {16'b0, SIG}, {16'b0, held_sig});
                check("hold_tog", {16'b0, TOGGLES}, {16'b0, held_tog});
                // START together with ack: only the ack acts
                START = 1'b1;
                do_ack("hold");
                START = 1'b0;
                tick();
                check("ack_start_busy", {31'b0, BUSY}, 32'h0);
                check("after_ack_sig", {16'b0, SIG}, {16'b0, held_sig});
                check("after_ack_tog", {16'b0, TOGGLES}, {16'b0, held_tog});
            end else begin
                do_ack($sformatf("tbl%0d", k));
            end
        end

        // BUSY high exactly one cycle for NCYC=1
        set_vec(6'h00);
        START = 1'b1;
        NCYC = 10'd1;
        busy_cnt = 0;
        tick();
        START = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (BUSY === 1'b1) busy_cnt++;
            tick();
        end
        check("busy_one_cycle", busy_cnt, 1);
        check("busy1_sig", {16'b0, SIG}, 32'hEFDF);
        do_ack("busy1");

        // SIG_ACK in IDLE is ignored
        held_sig = SIG;
        SIG_ACK = 1'b1;
        tick();
        tick();
        SIG_ACK = 1'b0;
        check("idle_ack_valid", {31'b0, SIG_VALID}, 32'h0);
        check("idle_ack_busy", {31'b0, BUSY}, 32'h0);
        check("idle_ack_sig", {16'b0, SIG}, {16'b0, held_sig});

        // START pulse mid-RUN ignored
        vq.delete();
        vq.push_back(6'h15);
        for (int i = 0; i < 6; i++) vq.push_back(6'($urandom_range(0, 63)));
        do_run("midstart", 6, 2);
        model(6);
        check("midstart_sig", {16'b0, SIG}, {16'b0, m_sig});
        check("midstart_tog", {16'b0, TOGGLES}, {16'b0, m_tog});
        do_ack("midstart");

        // Reset at capture 3 of an 8-capture run
        set_vec(6'h2A);
        START = 1'b1;
        NCYC = 10'd8;
        tick();
        START = 1'b0;
        set_vec(6'h11);
        tick();
        set_vec(6'h22);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_sig", {16'b0, SIG}, 32'h0);
        check("abort_tog", {16'b0, TOGGLES}, 32'h0);
        check("abort_valid", {31'b0, SIG_VALID}, 32'h0);
        check("abort_busy", {31'b0, BUSY}, 32'h0);
        vq.delete();
        vq.push_back(6'h00);
        vq.push_back(6'h00);
        do_run("post_abort", 1, 0);
        check("post_abort_sig", {16'b0, SIG}, 32'hEFDF);
        do_ack("post_abort");

        // Randomized runs, one at full length
        for (int r = 0; r < 16; r++) begin
            int n;
            n = (r == 15) ? 1023 : int'($urandom_range(1, 40));
            vq.delete();
            for (int i = 0; i <= n; i++)
                vq.push_back(($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) :
                             (i == 0 ? 6'h0 : vq[i-1]));
            do_run($sformatf("rnd%0d", r), n, 0);
            model(n);
            check($sformatf("rnd%0d_sig", r), {16'b0, SIG}, {16'b0, m_sig});
            check($sformatf("rnd%0d_tog", r), {16'b0, TOGGLES}, {16'b0, m_tog});
            for (int c = 0; c < int'($urandom_range(0, 3)); c++) tick();
            do_ack($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s298_resp_misr.md
Name: s298_resp_misr

Overview:
- Response compactor directly downstream of the s298 controller; consumes its six outputs G66, G67, G117, G118, G132, G133.
- On START, compresses a programmed number of consecutive output vectors into a 16-bit MISR signature and counts output-vector changes.
- Presents the result with a valid/ack handshake. Used by the timing-closure bench to check the controller netlist after cell resizing without tracing every cycle.

Parameters:
- SIG_W, 16, signature width; the feedback rules below assume 16.
- CYC_W, 10, width of the capture-cycle counter.
- POLY, 16'h1021, MISR feedback polynomial (x^16+x^12+x^5+1).
- SEED, 16'hFFFF, signature value loaded on START.

Ports:
- CK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- START  in  1  begin a capture run; sampled only in IDLE.
- NCYC  in  CYC_W  number of vectors to capture; sampled with START.
- G66, G67, G117, G118, G132, G133  in  1 each  s298 outputs.
- BUSY  out  1  high in RUN.
- SIG  out  SIG_W  signature; stable while SIG_VALID is high.
- SIG_VALID  out  1  signature ready.
- SIG_ACK  in  1  consumer accepts the signature.
- TOGGLES  out  16  number of captured cycles whose vector differed from the previous vector.

Behaviour:
- Vector v[5:0] = {G133, G132, G118, G117, G67, G66}. Bit 0 is G66.
- Reset (synchronous, active-high):
  - state = IDLE.
  - SIG = 0, TOGGLES = 0, BUSY = 0, SIG_VALID = 0.
  - Counter = 0, prev = 0.
- RST has priority over every other input in every state. A reset mid-RUN or mid-HOLD aborts the run; there is no partial result.
- States are IDLE, RUN and HOLD.
- IDLE:
  - START=1 and NCYC!=0 at edge k:
    - SIG <= SEED, TOGGLES <= 0, counter <= NCYC, prev <= v.
    - Go to RUN.
  - START=1 with NCYC==0 is ignored; the block stays in IDLE.
  - SIG and TOGGLES keep their last values in IDLE.
- RUN: captures on edges k+1 .. k+NCYC, exactly NCYC captures. At each capture edge:
  - SIG <= {SIG[14:0],1'b0} ^ (SIG[15] ? POLY : 0) ^ {10'b0, v}.
  - If v != prev, TOGGLES <= TOGGLES+1, saturating at 16'hFFFF. Then prev <= v.
  - counter <= counter-1.
  - At the capture where counter==1: go to HOLD and set SIG_VALID <= 1 on that same edge.
- HOLD:
  - SIG_VALID = 1. SIG and TOGGLES frozen.
  - SIG_ACK=1 at an edge: go to IDLE and SIG_VALID <= 0. SIG and TOGGLES keep their values.
  - SIG_VALID stays high indefinitely without an ack.
- START in RUN or HOLD is ignored. SIG_ACK outside HOLD is ignored.
- START and SIG_ACK together in HOLD: only the ack takes effect. A new run needs START in a later IDLE cycle.
- Inputs G* are sampled directly, with no internal synchronizer; the upstream block is on the same CK.
- Latency: START edge to SIG_VALID high is NCYC edges.
- Maximum run length is 2^CYC_W-1 = 1023 captures.

Optional Feature:
- Macro: S298_RESP_XMASK_EN.
- Defined:
  - Adds input port XMASK [5:0].
  - v is replaced by v & ~XMASK, sampled at each capture edge and at the START edge, for both the MISR and the toggle compare.
  - Masks unknown or unstable controller outputs during gate-level simulation.
- Undefined:
  - Port XMASK is absent; v is used unmasked.
  - Logic is identical to the defined case with XMASK = 0.

Test Plan:
- All G*=0, START with NCYC=1 → SIG_VALID rises 1 edge later; SIG=16'hEFDF; TOGGLES=0; BUSY high exactly 1 cycle.
- All G*=0, NCYC=2 → SIG=16'hCF9F after 2 edges.
- G* = 6'h3F constant (v=3F at START), NCYC=1 → SIG=16'hEFE0; TOGGLES=0.
- v=00 at START, then 3F,00,3F,00 on the captures, NCYC=4 → TOGGLES=4; SIG_VALID held for 5 cycles with no ack; ack drops it the next cycle; SIG unchanged afterwards.
- Protocol checks:
  - START with NCYC=0 → stays IDLE, BUSY=0.
  - START pulses during RUN and HOLD → no effect.
  - SIG_ACK in IDLE → no effect.
- RST asserted at capture 3 of an NCYC=8 run → next cycle IDLE, SIG=0, TOGGLES=0, SIG_VALID=0. A subsequent NCYC=1 run on zero inputs → SIG=16'hEFDF.
